// File: rtl/dcache_mshr.sv
// rtl/dcache_mshr.sv - miss status holding registers between the dcache controller and main memory
// Tracks outstanding loads/stores, issues them in allocation order and returns load fills by memory tag.
module dcache_mshr #(
  parameter int NUM_MSHR = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [1:0]  proc2Dmem_size,
  input  logic [63:0] proc2Dmem_data,
  output logic        dmem_req_ready,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [1:0]  proc2mem_size,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic [4:0]  Dmem2proc_idx,
  output logic [7:0]  Dmem2proc_tag,
  output logic [63:0] Dmem2proc_data,
  output logic        Dmem2proc_valid
);
  localparam int IDX_W = $clog2(NUM_MSHR);
  localparam logic [1:0] BUS_NONE    = 2'd0;
  localparam logic [1:0] BUS_LOAD    = 2'd1;
  localparam logic [1:0] BUS_STORE   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  typedef enum logic {PEND = 1'b0, WAIT = 1'b1} ent_state_e;

  logic [NUM_MSHR-1:0] valid_q, valid_d, is_store_q, is_store_d;
  ent_state_e          state_q [NUM_MSHR];
  ent_state_e          state_d [NUM_MSHR];
  logic [31:0]         addr_q [NUM_MSHR];
  logic [31:0]         addr_d [NUM_MSHR];
  logic [1:0]          size_q [NUM_MSHR];
  logic [1:0]          size_d [NUM_MSHR];
  logic [63:0]         data_q [NUM_MSHR];
  logic [63:0]         data_d [NUM_MSHR];
  logic [3:0]          mem_tag_q [NUM_MSHR];
  logic [3:0]          mem_tag_d [NUM_MSHR];
  logic [IDX_W-1:0]    fifo_q [NUM_MSHR];
  logic [IDX_W-1:0]    fifo_d [NUM_MSHR];
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]      count_q, count_d;
  logic                fill_valid_q, fill_valid_d;
  logic [4:0]          fill_idx_q, fill_idx_d;
  logic [7:0]          fill_tag_q, fill_tag_d;
  logic [63:0]         fill_data_q, fill_data_d;

  logic                req_valid, merge_hit, free_found, fill_hit, alloc, pop;
  logic [IDX_W-1:0]    free_idx, fill_sel, head_idx;

  assign head_idx = fifo_q[head_q];

  // A fill-matched entry is excluded from merging: it is being freed this cycle.
  always_comb begin
    fill_hit   = 1'b0;
    fill_sel   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    merge_hit  = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (mem2proc_tag != 4'd0 && valid_q[i] && state_q[i] == WAIT && mem_tag_q[i] == mem2proc_tag) begin
        fill_hit = 1'b1;
        fill_sel = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (proc2Dmem_command == BUS_LOAD && valid_q[i] && !is_store_q[i] &&
          addr_q[i][31:3] == proc2Dmem_addr[31:3] && !(fill_hit && fill_sel == IDX_W'(i))) begin
        merge_hit = 1'b1;
      end
    end
    req_valid      = proc2Dmem_command != BUS_NONE;
    dmem_req_ready = req_valid && (merge_hit || free_found);
    alloc          = req_valid && !merge_hit && free_found;
    pop            = count_q != '0 && mem2proc_response != 4'd0;
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_size    = '0;
    proc2mem_data    = '0;
    if (count_q != '0) begin
      if (is_store_q[head_idx]) begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = addr_q[head_idx];
        proc2mem_size    = size_q[head_idx];
        proc2mem_data    = data_q[head_idx];
      end else begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = {addr_q[head_idx][31:3], 3'b000};
        proc2mem_size    = SIZE_DOUBLE;
      end
    end
  end

  // Allocation only sees valid_q, so entries freed this cycle become reusable next cycle.
  always_comb begin
    valid_d     = valid_q;
    is_store_d  = is_store_q;
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    mem_tag_d   = mem_tag_q;
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fill_valid_d = fill_hit;
    fill_idx_d  = fill_idx_q;
    fill_tag_d  = fill_tag_q;
    fill_data_d = fill_data_q;
    if (pop) begin
      head_d = head_q + 1'b1;
      if (is_store_q[head_idx]) begin
        valid_d[head_idx] = 1'b0;
      end else begin
        state_d[head_idx]   = WAIT;
        mem_tag_d[head_idx] = mem2proc_response;
      end
    end
    if (fill_hit) begin
      valid_d[fill_sel] = 1'b0;
      fill_idx_d  = addr_q[fill_sel][7:3];
      fill_tag_d  = addr_q[fill_sel][15:8];
      fill_data_d = mem2proc_data;
    end
    if (alloc) begin
      valid_d[free_idx]    = 1'b1;
      is_store_d[free_idx] = proc2Dmem_command == BUS_STORE;
      state_d[free_idx]    = PEND;
      addr_d[free_idx]     = proc2Dmem_addr;
      size_d[free_idx]     = proc2Dmem_size;
      data_d[free_idx]     = proc2Dmem_data;
      fifo_d[tail_q]       = free_idx;
      tail_d               = tail_q + 1'b1;
    end
    case ({alloc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      is_store_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
      fill_tag_q   <= '0;
      fill_data_q  <= '0;
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i]   <= PEND;
        addr_q[i]    <= '0;
        size_q[i]    <= '0;
        data_q[i]    <= '0;
        mem_tag_q[i] <= '0;
        fifo_q[i]    <= '0;
      end
    end else begin
      valid_q      <= valid_d;
      is_store_q   <= is_store_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      data_q       <= data_d;
      mem_tag_q    <= mem_tag_d;
      fifo_q       <= fifo_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      fill_valid_q <= fill_valid_d;
      fill_idx_q   <= fill_idx_d;
      fill_tag_q   <= fill_tag_d;
      fill_data_q  <= fill_data_d;
    end
  end

  assign Dmem2proc_valid = fill_valid_q;
  assign Dmem2proc_idx   = fill_idx_q;
  assign Dmem2proc_tag   = fill_tag_q;
  assign Dmem2proc_data  = fill_data_q;
endmodule

// File: tb/tb_dcache_mshr.sv
// tb/tb_dcache_mshr.sv - scoreboard bench for dcache_mshr
// Expected memory requests and fills are queued as stimulus is driven and compared when the DUT emits them.
module tb_dcache_mshr;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam logic [1:0] SZ_WORD   = 2'd2;
  localparam logic [1:0] SZ_DOUBLE = 2'd3;

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
  } mreq_t;

  typedef struct {
    logic [4:0]  idx;
    logic [7:0]  tag;
    logic [63:0] data;
  } fill_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  proc2Dmem_command = '0;
  logic [31:0] proc2Dmem_addr = '0;
  logic [1:0]  proc2Dmem_size = '0;
  logic [63:0] proc2Dmem_data = '0;
  logic        dmem_req_ready;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [1:0]  proc2mem_size;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response = '0;
  logic [63:0] mem2proc_data = '0;
  logic [3:0]  mem2proc_tag = '0;
  logic [4:0]  Dmem2proc_idx;
  logic [7:0]  Dmem2proc_tag;
  logic [63:0] Dmem2proc_data;
  logic        Dmem2proc_valid;

  int n_vec  = 0;
  int n_miss = 0;
  int issue_cnt = 0;
  int fill_cnt  = 0;
  mreq_t exp_mem[$];
  mreq_t pend_q[$];
  fill_t exp_fill[$];
  logic [31:0] wait_addr [16];

  dcache_mshr #(.NUM_MSHR(4)) dut (
    .clock(clock), .reset(reset),
    .proc2Dmem_command(proc2Dmem_command), .proc2Dmem_addr(proc2Dmem_addr),
    .proc2Dmem_size(proc2Dmem_size), .proc2Dmem_data(proc2Dmem_data),
    .dmem_req_ready(dmem_req_ready),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_size(proc2mem_size), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .Dmem2proc_idx(Dmem2proc_idx), .Dmem2proc_tag(Dmem2proc_tag),
    .Dmem2proc_data(Dmem2proc_data), .Dmem2proc_valid(Dmem2proc_valid)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1, so the negedge sees settled values for this cycle.
  always @(negedge clock) begin
    if (!reset && mem2proc_response != 4'd0 && proc2mem_command != BUS_NONE) begin
      issue_cnt++;
      check_eq("issue_expected", exp_mem.size() != 0, 1);
      if (exp_mem.size() != 0) begin
        mreq_t e;
        e = exp_mem.pop_front();
        check_eq("issue_cmd", proc2mem_command, e.cmd);
        check_eq("issue_addr", proc2mem_addr, e.addr);
        check_eq("issue_size", proc2mem_size, e.size);
        if (e.cmd == BUS_STORE) check_eq("issue_data", proc2mem_data, e.data);
      end
    end
    if (Dmem2proc_valid) begin
      fill_cnt++;
      check_eq("fill_expected", exp_fill.size() != 0, 1);
      if (exp_fill.size() != 0) begin
        fill_t f;
        f = exp_fill.pop_front();
        check_eq("fill_idx", Dmem2proc_idx, f.idx);
        check_eq("fill_tag", Dmem2proc_tag, f.tag);
        check_eq("fill_data", Dmem2proc_data, f.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] cmd, input logic [31:0] addr, input logic [1:0] size, input logic [63:0] data);
    proc2Dmem_command = cmd;
    proc2Dmem_addr    = addr;
    proc2Dmem_size    = size;
    proc2Dmem_data    = data;
  endtask

  task automatic push_req(input logic [1:0] cmd, input logic [31:0] addr, input logic [1:0] size, input logic [63:0] data);
    mreq_t e;
    e.cmd = cmd;
    if (cmd == BUS_STORE) begin
      e.addr = addr; e.size = size; e.data = data;
    end else begin
      e.addr = {addr[31:3], 3'b000}; e.size = SZ_DOUBLE; e.data = '0;
    end
    exp_mem.push_back(e);
    e.addr = addr;
    pend_q.push_back(e);
  endtask

  task automatic accept(input logic [1:0] cmd, input logic [31:0] addr, input logic [1:0] size, input logic [63:0] data);
    set_req(cmd, addr, size, data);
    #1;
    check_eq("accept_ready", dmem_req_ready, 1);
    push_req(cmd, addr, size, data);
    tick();
    set_req(BUS_NONE, '0, '0, '0);
  endtask

  task automatic issue(input logic [3:0] rsp);
    mreq_t e;
    mem2proc_response = rsp;
    if (pend_q.size() != 0) begin
      e = pend_q.pop_front();
      if (e.cmd != BUS_STORE) wait_addr[rsp] = e.addr;
    end
    tick();
    mem2proc_response = '0;
  endtask

  task automatic push_fill(input logic [3:0] t, input logic [63:0] d);
    fill_t f;
    f.idx = wait_addr[t][7:3];
    f.tag = wait_addr[t][15:8];
    f.data = d;
    exp_fill.push_back(f);
  endtask

  task automatic ret(input logic [3:0] t, input logic [63:0] d);
    mem2proc_tag  = t;
    mem2proc_data = d;
    push_fill(t, d);
    tick();
    mem2proc_tag = '0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_cmd"}, proc2mem_command, BUS_NONE);
    check_eq({tag, "_addr"}, proc2mem_addr, 0);
    check_eq({tag, "_size"}, proc2mem_size, 0);
    check_eq({tag, "_data"}, proc2mem_data, 0);
    check_eq({tag, "_fvalid"}, Dmem2proc_valid, 0);
    check_eq({tag, "_fidx"}, Dmem2proc_idx, 0);
    check_eq({tag, "_ftag"}, Dmem2proc_tag, 0);
    check_eq({tag, "_fdata"}, Dmem2proc_data, 0);
  endtask

  initial begin
    int i0, f0;
    #1;
    check_idle_outputs("rst");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle_outputs("post_rst");
    check_eq("none_ready", dmem_req_ready, 0);

    // Load miss with fill one cycle after the tag returns.
    accept(BUS_LOAD, 32'h0000_1238, SZ_WORD, '0);
    check_eq("ld_head_cmd", proc2mem_command, BUS_LOAD);
    issue(4'd3);
    ret(4'd3, {16{4'hA}});
    check_eq("ld_fill_valid", Dmem2proc_valid, 1);
    check_eq("ld_fill_idx", Dmem2proc_idx, 7);
    check_eq("ld_fill_tag", Dmem2proc_tag, 8'h12);
    tick();
    check_eq("ld_fill_pulse", Dmem2proc_valid, 0);

    // Same load held for 10 cycles merges into one entry.
    i0 = issue_cnt; f0 = fill_cnt;
    accept(BUS_LOAD, 32'h0000_2000, SZ_WORD, '0);
    for (int k = 0; k < 9; k++) begin
      set_req(BUS_LOAD, 32'h0000_2004, SZ_WORD, '0);
      #1;
      check_eq("merge_ready", dmem_req_ready, 1);
      tick();
    end
    set_req(BUS_NONE, '0, '0, '0);
    issue(4'd5);
    #1;
    check_eq("merge_single_entry", proc2mem_command, BUS_NONE);
    ret(4'd5, 64'h0123_4567_89AB_CDEF);
    tick();
    check_eq("merge_issue_cnt", issue_cnt - i0, 1);
    check_eq("merge_fill_cnt", fill_cnt - f0, 1);

    // Full: fifth load is stalled until the cycle after a fill frees an entry.
    accept(BUS_LOAD, 32'h0000_0100, SZ_WORD, '0);
    accept(BUS_LOAD, 32'h0000_0208, SZ_WORD, '0);
    accept(BUS_LOAD, 32'h0000_0310, SZ_WORD, '0);
    accept(BUS_LOAD, 32'h0000_0418, SZ_WORD, '0);
    set_req(BUS_LOAD, 32'h0000_0520, SZ_WORD, '0);
    #1;
    check_eq("full_ready", dmem_req_ready, 0);
    tick();
    issue(4'd7);
    #1;
    check_eq("full_after_issue_ready", dmem_req_ready, 0);
    mem2proc_tag = 4'd7;
    mem2proc_data = 64'h7777;
    push_fill(4'd7, 64'h7777);
    #1;
    check_eq("full_fill_cycle_ready", dmem_req_ready, 0);
    tick();
    mem2proc_tag = '0;
    #1;
    check_eq("full_freed_ready", dmem_req_ready, 1);
    push_req(BUS_LOAD, 32'h0000_0520, SZ_WORD, '0);
    tick();
    set_req(BUS_NONE, '0, '0, '0);
    for (int t = 8; t < 12; t++) issue(4'(t));
    for (int t = 11; t >= 8; t--) ret(4'(t), 64'(t) << 40);
    tick();

    // Store is re-presented while memory refuses, then freed without a fill.
    f0 = fill_cnt;
    accept(BUS_STORE, 32'h0000_0040, SZ_WORD, 64'h1234);
    for (int k = 0; k < 2; k++) begin
      check_eq("st_hold_cmd", proc2mem_command, BUS_STORE);
      check_eq("st_hold_addr", proc2mem_addr, 32'h40);
      check_eq("st_hold_data", proc2mem_data, 64'h1234);
      tick();
    end
    issue(4'd5);
    #1;
    check_eq("st_freed_cmd", proc2mem_command, BUS_NONE);
    check_eq("st_freed_addr", proc2mem_addr, 0);
    tick();
    tick();
    check_eq("st_no_fill", fill_cnt - f0, 0);

    // Out-of-order returns, then a same-line load during its entry's fill cycle.
    accept(BUS_LOAD, 32'h0000_3308, SZ_WORD, '0);
    accept(BUS_LOAD, 32'h0000_4410, SZ_WORD, '0);
    issue(4'd1);
    issue(4'd2);
    ret(4'd2, 64'hBBBB_0002);
    ret(4'd1, 64'hCCCC_0001);
    accept(BUS_LOAD, 32'h0000_6000, SZ_WORD, '0);
    issue(4'd3);
    mem2proc_tag = 4'd3;
    mem2proc_data = 64'h6060;
    push_fill(4'd3, 64'h6060);
    set_req(BUS_LOAD, 32'h0000_6000, SZ_WORD, '0);
    #1;
    check_eq("fillcyc_ready", dmem_req_ready, 1);
    push_req(BUS_LOAD, 32'h0000_6000, SZ_WORD, '0);
    tick();
    mem2proc_tag = '0;
    set_req(BUS_NONE, '0, '0, '0);
    check_eq("fillcyc_realloc_cmd", proc2mem_command, BUS_LOAD);
    issue(4'd6);
    ret(4'd6, 64'h6161);
    tick();

    // Unmatched tag is ignored; reset discards an entry waiting on tag 4.
    f0 = fill_cnt;
    mem2proc_tag = 4'd9;
    tick();
    mem2proc_tag = '0;
    tick();
    check_eq("unmatched_no_fill", fill_cnt - f0, 0);
    accept(BUS_LOAD, 32'h0000_5518, SZ_WORD, '0);
    issue(4'd4);
    reset = 1'b1;
    pend_q.delete();
    #1;
    check_idle_outputs("async_rst");
    tick();
    reset = 1'b0;
    f0 = fill_cnt;
    mem2proc_tag = 4'd4;
    mem2proc_data = 64'hDEAD_BEEF;
    tick();
    mem2proc_tag = '0;
    #1;
    check_idle_outputs("rst_wait");
    tick();
    check_eq("rst_wait_no_fill", fill_cnt - f0, 0);

    check_eq("mem_sb_drained", exp_mem.size(), 0);
    check_eq("fill_sb_drained", exp_fill.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dcache_mshr.md
DCACHE_MSHR -- requirements
Module: dcache_mshr

Interface
REQ-001 SHALL have parameter NUM_MSHR, default 4, giving the number of outstanding-request entries (power of two, 2..8).
REQ-002 SHALL use one clock and an asynchronous, active-high reset; the ports are named clock and reset.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 proc2Dmem_command  in  2  request from the dcache controller: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
REQ-006 proc2Dmem_addr  in  32  request byte address.
REQ-007 proc2Dmem_size  in  2  request size: BYTE, HALF, WORD, DOUBLE.
REQ-008 proc2Dmem_data  in  64  store write data.
REQ-009 dmem_req_ready  out  1  the current request is accepted or merged this cycle.
REQ-010 proc2mem_command, proc2mem_addr, proc2mem_size, proc2mem_data  out  2/32/2/64  request to main memory.
REQ-011 mem2proc_response  in  4  memory transaction tag; 0 = not accepted.
REQ-012 mem2proc_data  in  64  returned line data.
REQ-013 mem2proc_tag  in  4  tag of the returning data; 0 = no return.
REQ-014 Dmem2proc_idx  out  5, Dmem2proc_tag  out  8, Dmem2proc_data  out  64, Dmem2proc_valid  out  1  fill port to the dcache controller.

Function
REQ-015 Each entry SHALL hold: valid, state {PEND, WAIT}, is_store, addr[31:0], size, data[63:0], mem_tag[3:0].
REQ-016 A BUS_LOAD request whose addr[31:3] equals the addr[31:3] of a valid non-store entry SHALL be merged: no allocation, dmem_req_ready=1.
REQ-017 Any other non-NONE request SHALL be allocated to the lowest-index free entry in state PEND, and its index SHALL be pushed to the tail of an issue FIFO of depth NUM_MSHR.
REQ-018 When all entries are valid and the request is not merged, dmem_req_ready=0 and the request SHALL be dropped; upstream holds it.
REQ-019 dmem_req_ready SHALL be combinational from the current inputs and state; dmem_req_ready=0 when the command is BUS_NONE.
REQ-020 An entry freed in cycle N SHALL NOT be reallocated before cycle N+1.
REQ-021 Every cycle the issue FIFO is non-empty, proc2mem_* SHALL present the head entry: command BUS_STORE with addr, size and data for a store; BUS_LOAD with {addr[31:3],3'b0} and DOUBLE for a load.
REQ-022 If the FIFO is empty, proc2mem_command=BUS_NONE and addr, size and data SHALL be 0, 0 and 0.
REQ-023 If mem2proc_response is nonzero, the head SHALL be popped; a store entry SHALL be freed, and a load entry SHALL move to WAIT with mem_tag=mem2proc_response.
REQ-024 If mem2proc_response is 0, the head SHALL be re-presented unchanged in the next cycle.
REQ-025 When mem2proc_tag is nonzero and equals the mem_tag of a WAIT entry, that entry SHALL be freed.
REQ-026 In the cycle after the REQ-025 match, Dmem2proc_valid SHALL pulse 1 for one cycle, with Dmem2proc_idx=addr[7:3], Dmem2proc_tag=addr[15:8] and Dmem2proc_data equal to the registered mem2proc_data.
REQ-027 A mem2proc_tag that matches no WAIT entry SHALL be ignored.
REQ-028 Allocate, issue/pop and fill-free in the same cycle SHALL all take effect; a request arriving in its entry's fill cycle does not merge.
REQ-029 The FIFO head/tail pointers SHALL wrap modulo NUM_MSHR; the count SHALL never exceed NUM_MSHR.

Reset
REQ-030 On reset, all entries SHALL be invalid and the FIFO pointers and count SHALL be 0.
REQ-031 On reset, proc2mem_command=BUS_NONE, Dmem2proc_valid=0 and all data, addr and idx/tag outputs SHALL be 0.
REQ-032 Memory returns in flight at reset SHALL be discarded by REQ-027.

Verification
REQ-033 Load miss: BUS_LOAD 0x0000_1238, response=3 -> proc2mem addr=0x1238 DOUBLE; tag=3 with data 0xAA..AA -> next cycle valid=1, idx=7, tag=0x12.
REQ-034 Merge: same load held for 10 cycles -> exactly one memory BUS_LOAD and one fill pulse.
REQ-035 Full: 5 distinct loads, memory response held 0 -> dmem_req_ready=0 on the 5th; after one fill, the 5th is accepted the cycle after the free.
REQ-036 Store: BUS_STORE 0x40, WORD, data 0x1234, response 0 for 2 cycles then 5 -> held for 3 cycles then freed, no fill pulse.
REQ-037 Out-of-order return: loads accepted with tags 1 and 2, return tag 2 then tag 1 -> fills in return order with the correct idx/tag.
REQ-038 Reset while WAIT (tag 4) -> a later mem2proc_tag=4 gives no fill, and the outputs match REQ-031.
